cache_refill_ctrl: RTL and testbench



---
 rtl/cache_refill_ctrl.sv | 133 +++++++++++++
 tb/tb_cache_refill_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_refill_ctrl.sv
// Miss handler: writes back a dirty victim line, then fetches the missing line and streams it to the cache fill port.
// Clean miss fill_done at acceptance+BLOCK_SIZE+1 cycles (+BLOCK_SIZE if dirty); memory stalls via mem_ready hold every request.
module cache_refill_ctrl #(
  parameter int DATA_WIDTH  = 32,
  parameter int BLOCK_SIZE  = 4,
  parameter int OFFSET_BITS = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             miss_req,
  input  logic [DATA_WIDTH-1:0]            miss_addr,
  input  logic                             victim_dirty,
  input  logic [DATA_WIDTH-1:0]            victim_addr,
  input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] victim_data,
  output logic                             busy,
  output logic                             fill_valid,
  output logic [OFFSET_BITS-1:0]           fill_offset,
  output logic [DATA_WIDTH-1:0]            fill_data,
  output logic                             fill_done,
  output logic                             mem_req,
  output logic                             mem_we,
  output logic [DATA_WIDTH-1:0]            mem_addr,
  output logic [DATA_WIDTH-1:0]            mem_wdata,
  input  logic [DATA_WIDTH-1:0]            mem_rdata,
  input  logic                             mem_ready
);

  typedef enum logic [1:0] {IDLE, WB, RD, DONE} state_t;

  localparam logic [DATA_WIDTH-1:0] BASE_MASK =
    {{(DATA_WIDTH-OFFSET_BITS-2){1'b1}}, {(OFFSET_BITS+2){1'b0}}};
  localparam logic [OFFSET_BITS-1:0] LAST = OFFSET_BITS'(BLOCK_SIZE-1);

  state_t                  state;
  logic [OFFSET_BITS-1:0]  cnt;
  logic [OFFSET_BITS-1:0]  cnt_nxt;
  logic [DATA_WIDTH-1:0]   miss_base;
  logic [DATA_WIDTH-1:0]   victim_base;
  logic [DATA_WIDTH-1:0]   victim_words [BLOCK_SIZE];

  assign cnt_nxt = cnt + OFFSET_BITS'(1);

  // Bases are line aligned, so adding the word offset never carries into the tag.
  function automatic logic [DATA_WIDTH-1:0] word_addr(input logic [DATA_WIDTH-1:0] base,
                                                      input logic [OFFSET_BITS-1:0] idx);
    return base + DATA_WIDTH'({idx, 2'b00});
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      miss_base   <= '0;
      victim_base <= '0;
      for (int i = 0; i < BLOCK_SIZE; i++) victim_words[i] <= '0;
      busy        <= 1'b0;
      fill_valid  <= 1'b0;
      fill_offset <= '0;
      fill_data   <= '0;
      fill_done   <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
    end else begin
      fill_valid <= 1'b0;
      fill_done  <= 1'b0;
      case (state)
        IDLE: begin
          if (miss_req) begin
            miss_base   <= miss_addr & BASE_MASK;
            victim_base <= victim_addr & BASE_MASK;
            for (int i = 0; i < BLOCK_SIZE; i++)
              victim_words[i] <= victim_data[i*DATA_WIDTH +: DATA_WIDTH];
            cnt     <= '0;
            busy    <= 1'b1;
            mem_req <= 1'b1;
            if (victim_dirty) begin
              state     <= WB;
              mem_we    <= 1'b1;
              mem_addr  <= victim_addr & BASE_MASK;
              mem_wdata <= victim_data[0 +: DATA_WIDTH];
            end else begin
              state     <= RD;
              mem_we    <= 1'b0;
              mem_addr  <= miss_addr & BASE_MASK;
              mem_wdata <= '0;
            end
          end
        end
        WB: begin
          if (mem_ready) begin
            if (cnt == LAST) begin
              // mem_req stays high: the first read is issued on the same edge.
              state     <= RD;
              cnt       <= '0;
              mem_we    <= 1'b0;
              mem_addr  <= miss_base;
              mem_wdata <= '0;
            end else begin
              cnt       <= cnt_nxt;
              mem_addr  <= word_addr(victim_base, cnt_nxt);
              mem_wdata <= victim_words[cnt_nxt];
            end
          end
        end
        RD: begin
          if (mem_ready) begin
            fill_valid  <= 1'b1;
            fill_offset <= cnt;
            fill_data   <= mem_rdata;
            if (cnt == LAST) begin
              state     <= DONE;
              cnt       <= '0;
              fill_done <= 1'b1;
              mem_req   <= 1'b0;
              mem_addr  <= '0;
            end else begin
              cnt      <= cnt_nxt;
              mem_addr <= word_addr(miss_base, cnt_nxt);
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed bench for cache_refill_ctrl: vector table of refills plus reset, busy-ignore and back-to-back sequences.
module tb_cache_refill_ctrl;

  localparam int DW = 32;
  localparam int BS = 4;
  localparam int OB = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              miss_req = 1'b0;
  logic [DW-1:0]     miss_addr = '0;
  logic              victim_dirty = 1'b0;
  logic [DW-1:0]     victim_addr = '0;
  logic [BS*DW-1:0]  victim_data = '0;
  logic              busy, fill_valid, fill_done, mem_req, mem_we;
  logic [OB-1:0]     fill_offset;
  logic [DW-1:0]     fill_data, mem_addr, mem_wdata, mem_rdata;
  logic              mem_ready = 1'b0;

  cache_refill_ctrl #(.DATA_WIDTH(DW), .BLOCK_SIZE(BS), .OFFSET_BITS(OB)) dut (
    .clk(clk), .rst_n(rst_n), .miss_req(miss_req), .miss_addr(miss_addr),
    .victim_dirty(victim_dirty), .victim_addr(victim_addr), .victim_data(victim_data),
    .busy(busy), .fill_valid(fill_valid), .fill_offset(fill_offset), .fill_data(fill_data),
    .fill_done(fill_done), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] memf(input logic [DW-1:0] a);
    return 32'hDA7A_0000 ^ a;
  endfunction

  function automatic logic [DW-1:0] vword(input int k, input int i);
    return (32'h11 * (i + 1)) ^ (k << 16);
  endfunction

  // Main memory model with programmable wait states per transfer.
  logic [DW-1:0] mem [1024];
  assign mem_rdata = mem[mem_addr[11:2]];

  int waitn = 0;
  int stall = 0;
  always @(posedge clk) begin
    #1;
    if (!mem_req) begin
      mem_ready = 1'b0;
      stall = 0;
    end else if (mem_ready) begin
      stall = 1;
      mem_ready = (stall > waitn);
    end else begin
      stall++;
      mem_ready = (stall > waitn);
    end
  end

  logic          xfer_we [$];
  logic [DW-1:0] xfer_addr [$];
  logic [DW-1:0] xfer_dat [$];
  int            fill_off_q [$];
  logic [DW-1:0] fill_dat_q [$];
  int            done_cyc [$];
  int            busylow_q [$];
  int            done_cnt = 0;
  int            acc_cyc = 0;
  logic          pend = 1'b0;
  logic          p_we;
  logic [DW-1:0] p_addr, p_wdata;

  always @(negedge clk) begin
    if (!rst_n) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        check("stall_req_held", {63'd0, mem_req}, 64'd1);
        check("stall_we_held", {63'd0, mem_we}, {63'd0, p_we});
        check("stall_addr_held", {32'd0, mem_addr}, {32'd0, p_addr});
        check("stall_wdata_held", {32'd0, mem_wdata}, {32'd0, p_wdata});
      end
      pend = mem_req && !mem_ready;
      p_we = mem_we; p_addr = mem_addr; p_wdata = mem_wdata;
      if (mem_req && mem_ready) begin
        xfer_we.push_back(mem_we);
        xfer_addr.push_back(mem_addr);
        xfer_dat.push_back(mem_we ? mem_wdata : mem_rdata);
        if (mem_we) mem[mem_addr[11:2]] = mem_wdata;
      end
      if (fill_valid) begin
        fill_off_q.push_back(int'(fill_offset));
        fill_dat_q.push_back(fill_data);
      end
      if (fill_done) begin
        done_cnt++;
        done_cyc.push_back(cyc);
        check("done_with_valid", {63'd0, fill_valid}, 64'd1);
      end
      if (!busy) busylow_q.push_back(cyc);
    end
  end

  typedef struct {
    logic          dirty;
    logic [DW-1:0] maddr;
    logic [DW-1:0] vaddr;
    int            vk;
    int            wt;
    int            exp_done;
    logic [DW-1:0] exp_rbase;
    logic [DW-1:0] exp_wbase;
  } vec_t;

  task automatic clear_logs();
    xfer_we.delete(); xfer_addr.delete(); xfer_dat.delete();
    fill_off_q.delete(); fill_dat_q.delete(); done_cyc.delete(); busylow_q.delete();
    done_cnt = 0;
  endtask

  // Called at posedge+1; the following edge is the acceptance edge.
  task automatic start_miss(input vec_t v);
    clear_logs();
    waitn = v.wt;
    miss_addr = v.maddr;
    victim_addr = v.vaddr;
    victim_dirty = v.dirty;
    for (int i = 0; i < BS; i++) victim_data[i*DW +: DW] = vword(v.vk, i);
    check("busy_before_accept", {63'd0, busy}, 64'd0);
    miss_req = 1'b1;
    acc_cyc = cyc;
    @(posedge clk); #1;
    miss_req = 1'b0;
    check("busy_after_accept", {63'd0, busy}, 64'd1);
  endtask

  task automatic wait_done(input int n, input int bound);
    int k = 0;
    while (done_cnt < n && k < bound) begin
      @(posedge clk);
      k++;
    end
    #1;
    check("fill_done_seen", {63'd0, done_cnt >= n}, 64'd1);
  endtask

  task automatic verify(input vec_t v, input string tag);
    int n;
    int j;
    logic          ewe;
    logic [DW-1:0] ea;
    logic [DW-1:0] ed;
    n = v.dirty ? 2 * BS : BS;
    check($sformatf("%s_xfer_count", tag), 64'(xfer_we.size()), 64'(n));
    for (int i = 0; i < n && i < xfer_we.size(); i++) begin
      ewe = v.dirty && (i < BS);
      j = (v.dirty && i >= BS) ? i - BS : i;
      ea = (ewe ? v.exp_wbase : v.exp_rbase) + DW'(4 * j);
      ed = ewe ? vword(v.vk, j) : memf(ea);
      check($sformatf("%s_xfer%0d_we", tag, i), {63'd0, xfer_we[i]}, {63'd0, ewe});
      check($sformatf("%s_xfer%0d_addr", tag, i), {32'd0, xfer_addr[i]}, {32'd0, ea});
      check($sformatf("%s_xfer%0d_data", tag, i), {32'd0, xfer_dat[i]}, {32'd0, ed});
    end
    check($sformatf("%s_fill_count", tag), 64'(fill_off_q.size()), 64'(BS));
    for (int i = 0; i < BS && i < fill_off_q.size(); i++) begin
      check($sformatf("%s_fill%0d_off", tag, i), 64'(fill_off_q[i]), 64'(i));
      check($sformatf("%s_fill%0d_data", tag, i), {32'd0, fill_dat_q[i]},
            {32'd0, memf(v.exp_rbase + DW'(4 * i))});
    end
    check($sformatf("%s_done_count", tag), 64'(done_cnt), 64'd1);
    check($sformatf("%s_done_cycle", tag),
          64'(done_cyc.size() > 0 ? done_cyc[0] - acc_cyc + 1 : -1), 64'(v.exp_done));
    check($sformatf("%s_idle_busy", tag), {63'd0, busy}, 64'd0);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    start_miss(v);
    wait_done(1, 300);
    repeat (3) @(posedge clk);
    #1;
    verify(v, tag);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"}, {63'd0, busy}, 64'd0);
    check({tag, "_fill_valid"}, {63'd0, fill_valid}, 64'd0);
    check({tag, "_fill_done"}, {63'd0, fill_done}, 64'd0);
    check({tag, "_fill_offset"}, 64'(fill_offset), 64'd0);
    check({tag, "_fill_data"}, {32'd0, fill_data}, 64'd0);
    check({tag, "_mem_req"}, {63'd0, mem_req}, 64'd0);
    check({tag, "_mem_we"}, {63'd0, mem_we}, 64'd0);
    check({tag, "_mem_addr"}, {32'd0, mem_addr}, 64'd0);
    check({tag, "_mem_wdata"}, {32'd0, mem_wdata}, 64'd0);
  endtask

  vec_t vecs [5];
  vec_t v;
  int   k;
  int   gaps;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = memf(DW'(4 * i));
    //        dirty maddr          vaddr          vk wt done rbase          wbase
    vecs[0] = '{1'b0, 32'h0000_0134, 32'h0000_0000, 0, 0, 6,  32'h0000_0130, 32'h0};
    vecs[1] = '{1'b1, 32'h0000_0400, 32'h0000_0210, 0, 0, 10, 32'h0000_0400, 32'h0000_0210};
    vecs[2] = '{1'b0, 32'h0000_0134, 32'h0000_0000, 0, 3, 18, 32'h0000_0130, 32'h0};
    vecs[3] = '{1'b1, 32'h0000_043F, 32'h0000_021C, 1, 1, 18, 32'h0000_0430, 32'h0000_0210};
    vecs[4] = '{1'b0, 32'h0000_0FFF, 32'h0000_0000, 0, 2, 14, 32'h0000_0FF0, 32'h0};

    #2;
    check_outputs_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check_outputs_zero("post_reset");

    for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Second miss during RD must be dropped.
    v = vecs[0];
    start_miss(v);
    @(posedge clk); #1;
    miss_addr = 32'h0000_0800;
    miss_req = 1'b1;
    @(posedge clk); #1;
    miss_req = 1'b0;
    wait_done(1, 100);
    repeat (10) @(posedge clk);
    #1;
    verify(v, "ignore");

    // Reset after two fill strobes: immediate clear, no completion.
    start_miss(vecs[0]);
    k = 0;
    while (fill_off_q.size() < 2 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("rst_fills_before", 64'(fill_off_q.size()), 64'd2);
    #1 rst_n = 1'b0;
    #1;
    check_outputs_zero("midrst");
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("midrst_no_done", 64'(done_cnt), 64'd0);
    check("midrst_busy", {63'd0, busy}, 64'd0);
    v = '{1'b0, 32'h0000_00F8, 32'h0, 0, 1, 10, 32'h0000_00F0, 32'h0};
    run_vec(v, "after_rst");

    // miss_req held high: refills chain with a one-cycle idle gap.
    clear_logs();
    waitn = 0;
    victim_dirty = 1'b0;
    miss_addr = 32'h0000_0500;
    miss_req = 1'b1;
    wait_done(3, 100);
    miss_req = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    if (done_cyc.size() >= 3) begin
      check("b2b_period1", 64'(done_cyc[1] - done_cyc[0]), 64'd6);
      check("b2b_period2", 64'(done_cyc[2] - done_cyc[1]), 64'd6);
      gaps = 0;
      foreach (busylow_q[i])
        if (busylow_q[i] > done_cyc[0] && busylow_q[i] < done_cyc[2]) gaps++;
      check("b2b_busy_gaps", 64'(gaps), 64'd2);
    end else begin
      check("b2b_done_count", 64'(done_cyc.size()), 64'd3);
    end
    check("b2b_fill_total", {63'd0, fill_off_q.size() >= 12}, 64'd1);
    check("b2b_last_read", {32'd0, xfer_addr.size() > 11 ? xfer_addr[11] : 32'hFFFF_FFFF},
          {32'd0, 32'h0000_050C});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
